// File: rtl/alu_sequencer.sv
// Multi-cycle issue sequencer: accepts one instruction, reads two operands,
// drives the ALU, writes the result back and maintains the C/Z/P flags.
module alu_sequencer #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*AW+2:0]     instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [AW-1:0]       rf_raddr_a,
    output logic [AW-1:0]       rf_raddr_b,
    input  logic [DW-1:0]       rf_rdata_a,
    input  logic [DW-1:0]       rf_rdata_b,
    output logic                rf_we,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic [2:0]          alu_cmd,
    output logic [DW-1:0]       alu_inA,
    output logic [DW-1:0]       alu_inB,
    output logic                alu_sc_i,
    input  logic [DW-1:0]       alu_rslt,
    input  logic                alu_sc_o,
    input  logic                alu_zero,
    input  logic                alu_pari,
    output logic                flag_c,
    output logic                flag_z,
    output logic                flag_p,
    output logic                done,
    output logic                err
);

    localparam int unsigned OPW = 3;
    localparam int unsigned IW  = OPW + 2 * AW;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_ROTL = 3'd1;
    localparam logic [OPW-1:0] OP_NAND = 3'd2;
    localparam logic [OPW-1:0] OP_SUB  = 3'd3;
    localparam logic [OPW-1:0] OP_CMP  = 3'd4;
    localparam logic [OPW-1:0] OP_MOV  = 3'd5;
    localparam logic [OPW-1:0] OP_CLRC = 3'd6;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_ROTL = 3'b001;
    localparam logic [2:0] CMD_NAND = 3'b010;
    localparam logic [2:0] CMD_SUB  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    instr_q, instr_d;
    logic             sc_q, sc_d;
    logic             zero_q, zero_d;
    logic             pari_q, pari_d;
    logic [2:0]       alu_cmd_q, alu_cmd_d;
    logic [DW-1:0]    alu_ina_q, alu_ina_d;
    logic [DW-1:0]    alu_inb_q, alu_inb_d;
    logic             alu_sci_q, alu_sci_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_p_q, flag_p_d;

    logic [OPW-1:0]   op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs;
    logic             op_writes;
    logic             op_all_flags;

    assign op           = instr_q[IW-1 -: OPW];
    assign rd           = instr_q[2*AW-1 -: AW];
    assign rs           = instr_q[AW-1:0];
    assign op_writes    = (op == OP_ADD) || (op == OP_ROTL) || (op == OP_NAND) ||
                          (op == OP_SUB) || (op == OP_MOV);
    assign op_all_flags = (op == OP_ADD) || (op == OP_ROTL) || (op == OP_NAND) ||
                          (op == OP_SUB) || (op == OP_CMP);

    assign instr_ready = (state_q == S_IDLE);
    assign rf_raddr_a  = rd;
    assign rf_raddr_b  = rs;

    // Next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        sc_d       = sc_q;
        zero_d     = zero_q;
        pari_d     = pari_q;
        alu_cmd_d  = alu_cmd_q;
        alu_ina_d  = alu_ina_q;
        alu_inb_d  = alu_inb_q;
        alu_sci_d  = alu_sci_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        flag_p_d   = flag_p_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Operand latches double as the ALU drive registers seen in EXEC
                alu_sci_d = flag_c_q;
                case (op)
                    OP_ADD: begin
                        alu_cmd_d = CMD_ADD;
                        alu_ina_d = rf_rdata_a;
                        alu_inb_d = rf_rdata_b;
                    end
                    OP_ROTL: begin
                        alu_cmd_d = CMD_ROTL;
                        alu_ina_d = rf_rdata_a;
                        alu_inb_d = DW'(0);
                    end
                    OP_NAND: begin
                        alu_cmd_d = CMD_NAND;
                        alu_ina_d = rf_rdata_a;
                        alu_inb_d = rf_rdata_b;
                    end
                    OP_SUB, OP_CMP: begin
                        alu_cmd_d = CMD_SUB;
                        alu_ina_d = rf_rdata_a;
                        alu_inb_d = rf_rdata_b;
                    end
                    OP_MOV: begin
                        alu_cmd_d = CMD_ADD;
                        alu_ina_d = DW'(0);
                        alu_inb_d = rf_rdata_b;
                    end
                    default: begin
                        alu_sci_d = alu_sci_q;
                    end
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                sc_d       = alu_sc_o;
                zero_d     = alu_zero;
                pari_d     = alu_pari;
                rf_waddr_d = rd;
                if (op_writes) begin
                    rf_wdata_d = alu_rslt;
                end
                rf_we_d    = op_writes;
                done_d     = 1'b1;
                err_d      = (op == 3'd7);
                state_d    = S_WB;
            end
            S_WB: begin
                if (op_all_flags) begin
                    flag_c_d = sc_q;
                    flag_z_d = zero_q;
                    flag_p_d = pari_q;
                end else if (op == OP_MOV) begin
                    flag_z_d = zero_q;
                    flag_p_d = pari_q;
                end else if (op == OP_CLRC) begin
                    flag_c_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            sc_q       <= 1'b0;
            zero_q     <= 1'b0;
            pari_q     <= 1'b0;
            alu_cmd_q  <= '0;
            alu_ina_q  <= '0;
            alu_inb_q  <= '0;
            alu_sci_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_p_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            sc_q       <= sc_d;
            zero_q     <= zero_d;
            pari_q     <= pari_d;
            alu_cmd_q  <= alu_cmd_d;
            alu_ina_q  <= alu_ina_d;
            alu_inb_q  <= alu_inb_d;
            alu_sci_q  <= alu_sci_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            flag_p_q   <= flag_p_d;
        end
    end

    assign alu_cmd  = alu_cmd_q;
    assign alu_inA  = alu_ina_q;
    assign alu_inB  = alu_inb_q;
    assign alu_sc_i = alu_sci_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;
    assign flag_p   = flag_p_q;

endmodule
